// File: rtl/cnv_row_acc.sv
// Convolution row accumulator: reduces KERNEL_SIZE MAC lanes into a seeded row buffer, then drains it.
// Optional saturation with a sticky overflow flag when CNV_ROW_ACC_SAT_EN is defined.
module cnv_row_acc #(
  parameter int KERNEL_SIZE = 3,
  parameter int MAC_WIDTH   = 21,
  parameter int PSUM_WIDTH  = 24,
  parameter int LENPSUM     = 16,
  localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          PECCNV_StaRow,
  input  logic                          PECCNV_BypIn,
  input  logic                          PECCNV_Abt,
  input  logic [PSUM_WIDTH*LENPSUM-1:0] CNVIN_Psum,
  input  logic                          MACCNV_Vld,
  output logic                          CNVMAC_Rdy,
  input  logic [MAC_WIDTH*KERNEL_SIZE-1:0] MACCNV_Mac,
  output logic                          CNVOUT_Vld,
  input  logic                          CNVOUT_Rdy,
  output logic [PSUM_WIDTH-1:0]         CNVOUT_Psum,
  output logic [AW-1:0]                 CNVOUT_Addr,
  output logic                          CNVOUT_Last,
  output logic                          CNVPEC_FnhRow,
  output logic                          CNVPEC_Busy,
  output logic                          CNVPEC_Ovf
);

  localparam logic [AW-1:0] LAST = AW'(LENPSUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_t;

  state_t state;
  logic [AW-1:0] addr;
  logic [PSUM_WIDTH-1:0] psum_buf [LENPSUM];
  logic fnh_q;
  logic ovf_q;

  logic signed [MAC_WIDTH-1:0]  lane;
  logic signed [PSUM_WIDTH-1:0] lane_sum;
  logic signed [PSUM_WIDTH-1:0] cur;
  logic [PSUM_WIDTH-1:0]        wr_val;
  logic                         clip;
  logic                         acc_hs;
  logic                         out_hs;
  logic                         at_last;

  always_comb begin
    lane_sum = '0;
    lane     = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      lane     = MACCNV_Mac[k*MAC_WIDTH +: MAC_WIDTH];
      lane_sum = lane_sum + PSUM_WIDTH'(lane);
    end
  end

  assign cur = psum_buf[addr];

`ifdef CNV_ROW_ACC_SAT_EN
  localparam logic [PSUM_WIDTH-1:0] PMAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PMIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  logic signed [PSUM_WIDTH:0] wide;

  // One guard bit exposes overflow of the seed add.
  always_comb begin
    wide = {cur[PSUM_WIDTH-1], cur} +
           {lane_sum[PSUM_WIDTH-1], lane_sum};
    clip = wide[PSUM_WIDTH] != wide[PSUM_WIDTH-1];
    if (!clip)
      wr_val = wide[PSUM_WIDTH-1:0];
    else if (wide[PSUM_WIDTH])
      wr_val = PMIN;
    else
      wr_val = PMAX;
  end
`else
  always_comb begin
    wr_val = cur + lane_sum;
    clip   = 1'b0;
  end
`endif

  assign at_last = addr == LAST;
  assign acc_hs  = (state == ACC) && MACCNV_Vld;
  assign out_hs  = (state == DRAIN) && CNVOUT_Rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      fnh_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < LENPSUM; i++)
        psum_buf[i] <= '0;
    end else begin
      fnh_q <= 1'b0;
      case (state)
        IDLE: begin
          if (PECCNV_StaRow && !PECCNV_Abt) begin
            for (int i = 0; i < LENPSUM; i++)
              psum_buf[i] <= PECCNV_BypIn ? '0 :
                CNVIN_Psum[i*PSUM_WIDTH +: PSUM_WIDTH];
            addr  <= '0;
            ovf_q <= 1'b0;
            state <= ACC;
          end
        end
        ACC: begin
          if (PECCNV_Abt) begin
            state <= IDLE;
            addr  <= '0;
          end else if (acc_hs) begin
            psum_buf[addr] <= wr_val;
            ovf_q <= ovf_q | clip;
            if (at_last) begin
              addr  <= '0;
              state <= DRAIN;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (PECCNV_Abt) begin
            state <= IDLE;
            addr  <= '0;
          end else if (out_hs) begin
            if (at_last) begin
              addr  <= '0;
              state <= IDLE;
              fnh_q <= 1'b1;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          addr  <= '0;
        end
      endcase
    end
  end

  assign CNVMAC_Rdy    = state == ACC;
  assign CNVOUT_Vld    = state == DRAIN;
  assign CNVOUT_Psum   = psum_buf[addr];
  assign CNVOUT_Addr   = addr;
  assign CNVOUT_Last   = (state == DRAIN) && at_last;
  assign CNVPEC_FnhRow = fnh_q;
  assign CNVPEC_Busy   = state != IDLE;
  assign CNVPEC_Ovf    = ovf_q;

endmodule

// File: tb/tb_cnv_row_acc.sv
// Directed bench for cnv_row_acc: seed, bypass, backpressure, abort, overflow, reset.
module tb_cnv_row_acc;

  localparam int KS = 3;
  localparam int MW = 21;
  localparam int PW = 24;
  localparam int LP = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sta = 1'b0;
  logic byp = 1'b0;
  logic abt = 1'b0;
  logic [PW*LP-1:0] in_psum = '0;
  logic mvld = 1'b0;
  logic mrdy;
  logic [MW*KS-1:0] mac = '0;
  logic ovld;
  logic ordy = 1'b1;
  logic [PW-1:0] opsum;
  logic [AW-1:0] oaddr;
  logic olast;
  logic fnh;
  logic busy;
  logic ovf;

  int total = 0;
  int bad = 0;
  logic [PW-1:0] exp_v [LP];

  always #5 clk = ~clk;

  cnv_row_acc #(
    .KERNEL_SIZE(KS), .MAC_WIDTH(MW),
    .PSUM_WIDTH(PW), .LENPSUM(LP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PECCNV_StaRow(sta), .PECCNV_BypIn(byp),
    .PECCNV_Abt(abt), .CNVIN_Psum(in_psum),
    .MACCNV_Vld(mvld), .CNVMAC_Rdy(mrdy),
    .MACCNV_Mac(mac), .CNVOUT_Vld(ovld),
    .CNVOUT_Rdy(ordy), .CNVOUT_Psum(opsum),
    .CNVOUT_Addr(oaddr), .CNVOUT_Last(olast),
    .CNVPEC_FnhRow(fnh), .CNVPEC_Busy(busy),
    .CNVPEC_Ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mac(input int m0, input int m1, input int m2);
    logic [31:0] a, b, c;
    a = m0; b = m1; c = m2;
    mac = {c[MW-1:0], b[MW-1:0], a[MW-1:0]};
  endtask

  task automatic start_row(input logic bp, input string nm);
    byp = bp;
    sta = 1'b1;
    tick();
    sta = 1'b0;
    total++;
    if (busy !== 1'b1 || mrdy !== 1'b1 || oaddr !== '0 || ovld !== 1'b0) begin
      bad++;
      $display("FAIL %s start: busy=%b rdy=%b addr=%0d vld=%b want 1 1 0 0",
               nm, busy, mrdy, oaddr, ovld);
    end
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        mvld = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      mvld = 1'b1;
      tick();
    end
    mvld = 1'b0;
  endtask

  task automatic drain(input string nm, input bit tog);
    for (int i = 0; i < LP; i++) begin
      if (tog) begin
        ordy = 1'b0;
        tick();
        total++;
        if (ovld !== 1'b1 || oaddr !== AW'(i) || opsum !== exp_v[i] ||
            olast !== (i == LP - 1)) begin
          bad++;
          $display("FAIL %s hold[%0d]: vld=%b addr=%0d psum=%h last=%b want psum=%h",
                   nm, i, ovld, oaddr, opsum, olast, exp_v[i]);
        end
        ordy = 1'b1;
      end
      total++;
      if (ovld !== 1'b1 || oaddr !== AW'(i) || opsum !== exp_v[i] ||
          olast !== (i == LP - 1)) begin
        bad++;
        $display("FAIL %s out[%0d]: vld=%b addr=%0d psum=%h last=%b want psum=%h",
                 nm, i, ovld, oaddr, opsum, olast, exp_v[i]);
      end
      tick();
    end
    total++;
    if (fnh !== 1'b1 || busy !== 1'b0 || ovld !== 1'b0) begin
      bad++;
      $display("FAIL %s fnh: fnh=%b busy=%b vld=%b want 1 0 0",
               nm, fnh, busy, ovld);
    end
    tick();
    total++;
    if (fnh !== 1'b0) begin
      bad++;
      $display("FAIL %s fnh_pulse: fnh=%b want 0", nm, fnh);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if ({mrdy, ovld, olast, fnh, busy, ovf} !== 6'b0 ||
        oaddr !== '0 || opsum !== '0) begin
      bad++;
      $display("FAIL reset: flags=%b addr=%0d psum=%h want 0",
               {mrdy, ovld, olast, fnh, busy, ovf}, oaddr, opsum);
    end
  endtask

  task automatic test_seed_acc();
    for (int i = 0; i < LP; i++) begin
      in_psum[i*PW +: PW] = PW'(i);
      exp_v[i] = PW'(i + 6);
    end
    start_row(1'b0, "t1");
    set_mac(1, 2, 3);
    feed(5, 1'b0);
    // a StaRow while accumulating must not reseed
    sta = 1'b1;
    in_psum = '1;
    feed(11, 1'b0);
    sta = 1'b0;
    total++;
    if (ovld !== 1'b1 || mrdy !== 1'b0) begin
      bad++;
      $display("FAIL t1 to_drain: vld=%b rdy=%b want 1 0", ovld, mrdy);
    end
    drain("t1", 1'b0);
  endtask

  task automatic test_bypass_neg();
    for (int i = 0; i < LP; i++) begin
      in_psum[i*PW +: PW] = 24'h7FFFFF;
      exp_v[i] = 24'hFFFFFD;
    end
    start_row(1'b1, "t2");
    set_mac(-5, 0, 2);
    feed(LP, 1'b0);
    drain("t2", 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LP; i++) begin
      in_psum[i*PW +: PW] = PW'(i * 100);
      exp_v[i] = PW'(i * 100 + 3);
    end
    start_row(1'b0, "t3");
    set_mac(1, 1, 1);
    feed(LP, 1'b1);
    drain("t3", 1'b1);
  endtask

  task automatic test_abort();
    start_row(1'b1, "t4");
    set_mac(1, 0, 0);
    feed(7, 1'b0);
    total++;
    if (oaddr !== 4'd7) begin
      bad++;
      $display("FAIL t4 addr_pre: addr=%0d want 7", oaddr);
    end
    abt = 1'b1;
    tick();
    abt = 1'b0;
    total++;
    if (busy !== 1'b0 || mrdy !== 1'b0 || fnh !== 1'b0 || oaddr !== '0) begin
      bad++;
      $display("FAIL t4 abort: busy=%b rdy=%b fnh=%b addr=%0d want 0 0 0 0",
               busy, mrdy, fnh, oaddr);
    end
    tick();
    total++;
    if (fnh !== 1'b0) begin
      bad++;
      $display("FAIL t4 no_fnh: fnh=%b want 0", fnh);
    end
    sta = 1'b1;
    abt = 1'b1;
    tick();
    sta = 1'b0;
    abt = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL t4 abt_wins: busy=%b want 0", busy);
    end
    for (int i = 0; i < LP; i++)
      exp_v[i] = PW'(1);
    start_row(1'b1, "t4r");
    feed(LP, 1'b0);
    drain("t4r", 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < LP; i++) begin
      in_psum[i*PW +: PW] = 24'h7FFFF0;
`ifdef CNV_ROW_ACC_SAT_EN
      exp_v[i] = 24'h7FFFFF;
`else
      exp_v[i] = 24'h8FFFEF;
`endif
    end
    start_row(1'b0, "t5");
    set_mac(32'h0FFFFF, 0, 0);
    feed(LP, 1'b0);
    total++;
`ifdef CNV_ROW_ACC_SAT_EN
    if (ovf !== 1'b1) begin
      bad++;
      $display("FAIL t5 ovf: ovf=%b want 1", ovf);
    end
`else
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL t5 ovf: ovf=%b want 0", ovf);
    end
`endif
    drain("t5", 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < LP; i++)
      exp_v[i] = PW'(3);
    start_row(1'b1, "t6");
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL t6 ovf_clr: ovf=%b want 0", ovf);
    end
    set_mac(1, 1, 1);
    feed(LP, 1'b0);
    repeat (5) tick();
    total++;
    if (oaddr !== 4'd5 || opsum !== 24'd3) begin
      bad++;
      $display("FAIL t6 pre: addr=%0d psum=%h want 5 000003", oaddr, opsum);
    end
    rst_n = 1'b0;
    sta = 1'b1;
    tick();
    total++;
    if ({mrdy, ovld, olast, fnh, busy, ovf} !== 6'b0 ||
        oaddr !== '0 || opsum !== '0) begin
      bad++;
      $display("FAIL t6 rst: flags=%b addr=%0d psum=%h want 0",
               {mrdy, ovld, olast, fnh, busy, ovf}, oaddr, opsum);
    end
    rst_n = 1'b1;
    sta = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || fnh !== 1'b0) begin
      bad++;
      $display("FAIL t6 idle: busy=%b fnh=%b want 0 0", busy, fnh);
    end
  endtask

  initial begin
    test_reset();
    test_seed_acc();
    test_bypass_neg();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
